multiplexer: RTL and testbench

MULTIPLEXER -- requirements
Module: multiplexer

---
 rtl/multiplexer_pkg.sv | 8 +
 rtl/multiplexer_mux4_comb.sv | 22 ++
 rtl/multiplexer.sv | 66 ++++++
 tb/tb_multiplexer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/multiplexer_pkg.sv
// Shared constants and types for the 4-lane multiplexer and its combinational selector.
package multiplexer_pkg;
    localparam int NUM_LANES  = 4;
    localparam int SEL_W      = 2;
    localparam int DW_DEFAULT = 1;

    typedef logic [DW_DEFAULT-1:0] lane_t;
endpackage

// File: rtl/multiplexer_mux4_comb.sv
// Combinational 4:1 lane selector; an unknown select yields all-X (don't-care in synthesis).
module mux4_comb
    import multiplexer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [SEL_W-1:0]        s,
    input  logic [NUM_LANES*DW-1:0] i,
    output logic [DW-1:0]           y
);

    always_comb begin
        case (s)
            2'b00:   y = i[0*DW +: DW];
            2'b01:   y = i[1*DW +: DW];
            2'b10:   y = i[2*DW +: DW];
            2'b11:   y = i[3*DW +: DW];
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/multiplexer.sv
// Four-lane multiplexer with a combinational output plus an optional registered copy
// and a select-change pulse that tracks the select seen at each enabled edge.
module multiplexer
    import multiplexer_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        S,
    input  logic [NUM_LANES*DW-1:0] I,
    input  logic                    en,
    output logic [DW-1:0]           Y,
    output logic [DW-1:0]           Y_q,
    output logic                    sel_chg
);

    mux4_comb #(.DW(DW)) u_mux4_comb (
        .s (S),
        .i (I),
        .y (Y)
    );

    if (REG_OUT) begin : g_reg
        logic [DW-1:0]    out_q, out_d;
        logic [SEL_W-1:0] s_q, s_d;
        logic             chg_q, chg_d;
        // primed_q blocks a spurious pulse on the first enabled edge after reset
        logic             primed_q, primed_d;

        always_comb begin
            out_d    = out_q;
            s_d      = s_q;
            primed_d = primed_q;
            chg_d    = 1'b0;
            if (en) begin
                out_d    = Y;
                s_d      = S;
                primed_d = 1'b1;
                chg_d    = primed_q && (S != s_q);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q    <= '0;
                s_q      <= '0;
                chg_q    <= 1'b0;
                primed_q <= 1'b0;
            end else begin
                out_q    <= out_d;
                s_q      <= s_d;
                chg_q    <= chg_d;
                primed_q <= primed_d;
            end
        end

        assign Y_q     = out_q;
        assign sel_chg = chg_q;
    end else begin : g_noreg
        assign Y_q     = '0;
        assign sel_chg = 1'b0;
    end

endmodule

// File: tb/tb_multiplexer.sv
// Bench for multiplexer: table-driven combinational vectors plus a scoreboard for the registered path.
module tb_multiplexer;
    import multiplexer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] S   = 2'b00;
    logic [3:0] I   = 4'b0000;
    logic       en  = 1'b0;
    lane_t      Y, Y_q;
    logic       sel_chg;

    int total = 0;
    int bad   = 0;

    multiplexer #(.DW(1), .REG_OUT(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .S       (S),
        .I       (I),
        .en      (en),
        .Y       (Y),
        .Y_q     (Y_q),
        .sel_chg (sel_chg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] s;
        logic [3:0] i;
        logic       y;
    } vec_t;

    typedef struct packed {
        logic yq;
        logic chg;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    // reference state for the registered path
    logic       m_yq     = 1'b0;
    logic [1:0] m_s      = 2'b00;
    logic       m_primed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_yq     = 1'b0;
        m_s      = 2'b00;
        m_primed = 1'b0;
        sb_q.delete();
    endtask

    // Drive inputs, push the expected post-edge values, clock once, pop and compare.
    task automatic step(input logic [1:0] s_in, input logic [3:0] i_in, input logic en_in,
                        input string name);
        exp_t e;
        S  = s_in;
        I  = i_in;
        en = en_in;
        #1;
        chk({name, "_y"}, {31'd0, Y}, {31'd0, i_in[s_in]});
        if (en_in) begin
            e.chg    = m_primed && (s_in != m_s);
            m_yq     = i_in[s_in];
            m_s      = s_in;
            m_primed = 1'b1;
        end else begin
            e.chg = 1'b0;
        end
        e.yq = m_yq;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_yq"},  {31'd0, Y_q},     {31'd0, e.yq});
            chk({name, "_chg"}, {31'd0, sel_chg}, {31'd0, e.chg});
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{s: 2'b00, i: 4'b0000, y: 1'b0};
        vecs[1] = '{s: 2'b00, i: 4'b0001, y: 1'b1};
        vecs[2] = '{s: 2'b01, i: 4'b0000, y: 1'b0};
        vecs[3] = '{s: 2'b01, i: 4'b0010, y: 1'b1};
        vecs[4] = '{s: 2'b01, i: 4'b0111, y: 1'b1};
        vecs[5] = '{s: 2'b01, i: 4'b0110, y: 1'b1};
        vecs[6] = '{s: 2'b11, i: 4'b1010, y: 1'b1};
        vecs[7] = '{s: 2'b11, i: 4'b0111, y: 1'b0};

        // asynchronous reset with no clock edge needed
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_yq",  {31'd0, Y_q},     32'd0);
        chk("rst_async_chg", {31'd0, sel_chg}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_yq", {31'd0, Y_q}, 32'd0);

        // combinational path, while still in reset and without clocks
        foreach (vecs[k]) begin
            S = vecs[k].s;
            I = vecs[k].i;
            #1;
            chk($sformatf("vec%0d_y", k), {31'd0, Y}, {31'd0, vecs[k].y});
        end
        for (int n = 0; n < 64; n++) begin
            logic [1:0] sv;
            logic [3:0] iv;
            sv = n[5:4];
            iv = n[3:0];
            S  = sv;
            I  = iv;
            #1;
            chk($sformatf("sweep_s%0d_i%0h", sv, iv), {31'd0, Y}, {31'd0, iv[sv]});
        end

        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // select step 00 -> 01 with en=1
        step(2'b00, 4'b0001, 1'b1, "first_en");
        step(2'b01, 4'b0001, 1'b1, "step01");
        step(2'b01, 4'b0011, 1'b1, "hold01_a");
        step(2'b01, 4'b0011, 1'b1, "hold01_b");

        // enable low: registered state must hold through changing inputs
        step(2'b10, 4'b0000, 1'b0, "dis_a");
        step(2'b11, 4'b1111, 1'b0, "dis_b");
        step(2'b00, 4'b0000, 1'b0, "dis_c");
        step(2'b11, 4'b1000, 1'b1, "reen");
        step(2'b11, 4'b1000, 1'b1, "reen_hold");
        step(2'b01, 4'b0010, 1'b1, "to01");

        // Y_q=1 with sel_chg pending, then reset between edges
        step(2'b10, 4'b0100, 1'b1, "pend");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_yq",  {31'd0, Y_q},     32'd0);
        chk("midrst_chg", {31'd0, sel_chg}, 32'd0);
        I = 4'b1011;
        S = 2'b10;
        #1;
        chk("midrst_y_a", {31'd0, Y}, 32'd0);
        S = 2'b11;
        #1;
        chk("midrst_y_b", {31'd0, Y}, 32'd1);
        @(posedge clk);
        #1;
        chk("midrst_hold_yq", {31'd0, Y_q}, 32'd0);
        rst = 1'b0;
        model_reset();

        // first enabled edge after reset: load but no pulse
        step(2'b10, 4'b0100, 1'b1, "post_rst");
        step(2'b00, 4'b0100, 1'b1, "post_rst_chg");
        step(2'b00, 4'b0100, 1'b1, "post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
